// File: rtl/sample_src_arbiter.sv
// -----------------------------------------------------------------------------
// sample_src_arbiter
//
// Round-robin arbiter and sequencer for the external 2:1 8-bit sample-path mux
// (mux_sel=1 -> A, mux_sel=0 -> B). Two probe sources, A and B, share one
// downstream capture port. A grant is held for a burst of up to BURST_LEN
// beats. The muxed byte is captured into a one-entry output register.
//
// Parameters
//   BURST_LEN  maximum beats per grant (>= 1)
//   CNT_W      width of the beat counters (only with ARB_STATS_EN)
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   a_valid/a_data/a_ready  source A stream (a_data feeds the mux A input)
//   b_valid/b_data/b_ready  source B stream (b_data feeds the mux B input)
//   mux_sel              mux select, 1=A 0=B, combinational from state
//   mux_out              muxed byte returned from the external mux
//   out_valid/out_data/out_src/out_ready  one-entry output register stream
//
// Optional feature, macro ARB_STATS_EN:
//   adds stats_clr (in), cnt_a / cnt_b (out, CNT_W) saturating beat counters.
//
// Handshake: every stream transfers a byte on a rising edge where valid and
// ready are both high. Ready never depends on the same stream's valid;
// a source may drop valid at any time, which releases its grant.
// -----------------------------------------------------------------------------
module sample_src_arbiter #(
  parameter int BURST_LEN = 8
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       mux_sel,
  input  logic [7:0] mux_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_src,
  input  logic       out_ready
`ifdef ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_src_q, last_src_d;  // 1 = A was granted last
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_src_q, out_src_d;

  logic            slot_free;
  logic            gnt_a;
  logic            gnt_b;
  logic            own_valid;
  logic            oth_valid;
  logic            xfer;

  // The data bytes only travel through the external mux; the arbiter itself
  // sees the selected byte on mux_out.
  logic            unused_data;
  assign unused_data = ^{a_data, b_data};

  always_comb begin
    gnt_a     = (state_q == GNT_A);
    gnt_b     = (state_q == GNT_B);
    slot_free = !out_valid_q || out_ready;
    a_ready   = gnt_a && slot_free;
    b_ready   = gnt_b && slot_free;
    mux_sel   = gnt_a;
    own_valid = gnt_a ? a_valid : b_valid;
    oth_valid = gnt_a ? b_valid : a_valid;
    xfer      = (a_valid && a_ready) || (b_valid && b_ready);

    state_d     = state_q;
    last_src_d  = last_src_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        // IDLE never moves a beat; it only picks the next owner.
        if (a_valid && b_valid) begin
          state_d = last_src_q ? GNT_B : GNT_A;
        end else if (a_valid) begin
          state_d = GNT_A;
        end else if (b_valid) begin
          state_d = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        // Grant ends on the last beat of a burst or as soon as the owner
        // drops valid. A stalled downstream keeps the grant forever.
        if (!own_valid || (xfer && (beat_cnt_q == LAST_BEAT))) begin
          last_src_d = gnt_a;
          beat_cnt_d = '0;
          if (oth_valid) begin
            state_d = gnt_a ? GNT_B : GNT_A;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase

    // A push in the same cycle as a pop keeps the slot full with the new byte.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_src_d   = gnt_a;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_src_q  <= 1'b0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_src_q  <= last_src_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Clear has priority over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (stats_clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (a_valid && a_ready && !(&cnt_a_q)) begin
        cnt_a_d = cnt_a_q + CNT_W'(1);
      end
      if (b_valid && b_ready && !(&cnt_b_q)) begin
        cnt_b_d = cnt_b_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
